// File: rtl/fetch_stage.sv
// IF stage of the rv32i pipeline: owns the PC, issues held instruction-memory
// reads, absorbs stalls into a hold buffer and drains stale reads after a redirect.
module fetch_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0060
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_resp,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_valid,
  output logic            if_id_load,
  output logic            if_id_flush,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, req_addr, req_addr_n;
  logic [XLEN-1:0] hold_instr, hold_instr_n, hold_pc, hold_pc_n;
  logic            read_c, valid_c;
  logic [XLEN-1:0] opc_c, oinstr_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= '0;
      hold_instr  <= '0;
      hold_pc     <= '0;
      fetch_count <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      if (if_id_load && !if_id_flush)
        fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    req_addr_n   = req_addr;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    read_c       = 1'b0;
    imem_address = pc;
    valid_c      = 1'b0;
    opc_c        = '0;
    oinstr_c     = '0;
    case (state)
      FETCH: begin
        read_c     = 1'b1;
        req_addr_n = pc;
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = imem_resp ? FETCH : DRAIN;
        end else if (imem_resp) begin
          valid_c  = 1'b1;
          opc_c    = pc;
          oinstr_c = imem_rdata;
          if (stall) begin
            hold_instr_n = imem_rdata;
            hold_pc_n    = pc;
            state_n      = HOLD;
          end else begin
            pc_n = pc + XLEN'(4);
          end
        end
      end
      HOLD: begin
        valid_c  = 1'b1;
        opc_c    = hold_pc;
        oinstr_c = hold_instr;
        if (redirect_valid) begin
          valid_c  = 1'b0;
          opc_c    = '0;
          oinstr_c = '0;
          pc_n     = redirect_pc;
          state_n  = FETCH;
        end else if (!stall) begin
          pc_n    = hold_pc + XLEN'(4);
          state_n = FETCH;
        end
      end
      DRAIN: begin
        read_c       = 1'b1;
        imem_address = req_addr;
        if (redirect_valid)
          pc_n = redirect_pc;
        // A response completes the stale read even when a newer redirect lands the same cycle.
        if (imem_resp)
          state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
  end

  assign imem_read   = read_c & ~rst;
  assign out_valid   = valid_c & ~rst;
  assign out_pc      = rst ? '0 : opc_c;
  assign out_instr   = rst ? '0 : oinstr_c;
  assign if_id_load  = ~rst & (redirect_valid | ~stall);
  assign if_id_flush = ~rst & (redirect_valid | ~valid_c);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycles against a bench-side
// memory model, with presented instructions checked through a scoreboard queue.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect_valid, imem_resp;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_read, out_valid, if_id_load, if_id_flush;
  logic [31:0] imem_address, out_pc, out_instr, fetch_count;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .out_pc(out_pc), .out_instr(out_instr), .out_valid(out_valid),
    .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, return at the following negedge for sampling.
  task automatic cyc(input logic s, input logic rv, input logic [31:0] rpc, input logic rsp);
    @(posedge clk);
    #1;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_resp      = rsp;
    imem_rdata     = rsp ? mem_word(imem_address) : 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic expect_pres(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && if_id_load && !if_id_flush) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e[63:32]);
        chk("sb_instr", out_instr, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;
    #3;
    chk("rst_read", imem_read, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_load", if_id_load, 0);
    chk("rst_flush", if_id_flush, 0);
    chk("rst_pc", out_pc, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_read", imem_read, 1);
    chk("rel_addr", imem_address, 32'h60);
    chk("rel_count", fetch_count, 0);

    // back-to-back reads, response one cycle after each request
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("t1_addr", imem_address, 32'h60 + 32'(4 * i));
      chk("t1_idle_flush", if_id_flush, 1);
      expect_pres(32'h60 + 32'(4 * i));
      cyc(0, 0, 0, 1);
      chk("t1_valid", out_valid, 1);
      chk("t1_load", if_id_load, 1);
      chk("t1_flush", if_id_flush, 0);
    end
    cyc(0, 0, 0, 0);
    chk("t1_count", fetch_count, 3);
    chk("t1_next", imem_address, 32'h6C);

    // stalled response goes to HOLD
    expect_pres(32'h6C);
    cyc(1, 0, 0, 1);
    chk("t2_valid", out_valid, 1);
    chk("t2_load", if_id_load, 0);
    cyc(1, 0, 0, 0);
    chk("t2_hold_read", imem_read, 0);
    chk("t2_hold_pc", out_pc, 32'h6C);
    chk("t2_hold_load", if_id_load, 0);
    cyc(0, 0, 0, 0);
    chk("t2_rel_load", if_id_load, 1);
    chk("t2_rel_flush", if_id_flush, 0);
    cyc(0, 0, 0, 0);
    chk("t2_next", imem_address, 32'h70);
    chk("t2_count", fetch_count, 4);

    // redirect with request outstanding drains the stale read
    cyc(0, 1, 32'h200, 0);
    chk("t3_load", if_id_load, 1);
    chk("t3_flush", if_id_flush, 1);
    chk("t3_valid", out_valid, 0);
    cyc(0, 0, 0, 0);
    chk("t3_drain_read", imem_read, 1);
    chk("t3_drain_addr", imem_address, 32'h70);
    cyc(0, 0, 0, 1);
    chk("t3_drop_valid", out_valid, 0);
    chk("t3_drop_flush", if_id_flush, 1);
    cyc(0, 0, 0, 0);
    chk("t3_target", imem_address, 32'h200);

    // redirect coincident with resp and stall
    cyc(1, 1, 32'h300, 1);
    chk("t4_valid", out_valid, 0);
    chk("t4_load", if_id_load, 1);
    chk("t4_flush", if_id_flush, 1);
    cyc(0, 0, 0, 0);
    chk("t4_target", imem_address, 32'h300);
    chk("t4_count", fetch_count, 4);
    expect_pres(32'h300);
    cyc(0, 0, 0, 1);

    // pc wrap at top of address space
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t5_top", imem_address, 32'hFFFF_FFFC);
    expect_pres(32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t5_wrap", imem_address, 32'h0);
    chk("t5_count", fetch_count, 6);

    // second redirect while draining wins
    cyc(0, 1, 32'h400, 0);
    cyc(0, 1, 32'h500, 0);
    chk("t6_drain_addr", imem_address, 32'h0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("t6_target", imem_address, 32'h500);

    // redirect while holding drops the held instruction
    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h600, 0);
    chk("t7_valid", out_valid, 0);
    chk("t7_flush", if_id_flush, 1);
    cyc(0, 0, 0, 0);
    chk("t7_target", imem_address, 32'h600);
    chk("t7_count", fetch_count, 6);

    // asynchronous reset in the middle of a drain
    cyc(0, 1, 32'h700, 0);
    cyc(0, 0, 0, 0);
    chk("t8_drain_addr", imem_address, 32'h600);
    #2;
    rst = 1'b1;
    #1;
    chk("t8_rst_read", imem_read, 0);
    chk("t8_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t8_pc", imem_address, 32'h60);
    chk("t8_read", imem_read, 1);
    chk("t8_count", fetch_count, 0);
    expect_pres(32'h60);
    cyc(0, 0, 0, 1);
    chk("t8_valid", out_valid, 1);
    cyc(0, 0, 0, 0);
    chk("t8_count1", fetch_count, 1);
    chk("t8_next", imem_address, 32'h64);

    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
